// File: rtl/timer_pkg.sv
// Shared constants, encodings and helpers for the time-of-day clock.
package timer_pkg;

    // Seven-segment patterns, active-low, bit 7 = decimal point (off).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2
    } field_t;

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_SET = 2'd1,
        MODE_RUN = 2'd2
    } mode_t;

    // Modular increment: m-1 (or anything beyond) wraps to 0.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] m);
        return (v >= m - 6'd1) ? '0 : v + 6'd1;
    endfunction

    // Modular decrement: 0 wraps to m-1.
    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] m);
        return (v == '0 || v >= m) ? m - 6'd1 : v - 6'd1;
    endfunction

    function automatic logic [3:0] digit_tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] digit_units(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    // Set-field rotation SEC -> MIN -> HOUR -> SEC.
    function automatic field_t next_field(input field_t f);
        case (f)
            FIELD_SEC:  return FIELD_MIN;
            FIELD_MIN:  return FIELD_HOUR;
            default:    return FIELD_SEC;
        endcase
    endfunction

endpackage

// File: rtl/timer_clock_gen2_seg7.sv
// Single-digit seven-segment decoder with blanking and polarity select.
module seg7_digit_decode
    import timer_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [7:0] pattern
);

    logic [7:0] low_pat;

    // Look up the active-low pattern, then flip it for active-high boards.
    always_comb begin
        low_pat = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    low_pat = SEG_0;
                4'd1:    low_pat = SEG_1;
                4'd2:    low_pat = SEG_2;
                4'd3:    low_pat = SEG_3;
                4'd4:    low_pat = SEG_4;
                4'd5:    low_pat = SEG_5;
                4'd6:    low_pat = SEG_6;
                4'd7:    low_pat = SEG_7;
                4'd8:    low_pat = SEG_8;
                4'd9:    low_pat = SEG_9;
                default: low_pat = SEG_BLANK;
            endcase
        end
        pattern = (SEG_ACTIVE_LOW != 0) ? low_pat : ~low_pat;
    end

endmodule

// File: rtl/timer_clock_gen2.sv
// Time-of-day clock: prescaled 1 Hz tick, HH:MM:SS counting with 12/24h wrap,
// key-driven field setting, daily alarm compare and six-digit segment outputs.
module timer_clock_gen2
    import timer_pkg::*;
#(
    parameter int TICK_DIV       = 100000000,
    parameter int HOUR_MOD       = 24,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_state,
    input  logic       set_mode,
    input  logic       select_key,
    input  logic       increase_key,
    input  logic       decrease_key,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] set_field,
    output logic       tick_1hz,
    output logic       alarm_hit,
    output logic [7:0] hour_tub_control_1,
    output logic [7:0] hour_tub_control_2,
    output logic [7:0] minute_tub_control_1,
    output logic [7:0] minute_tub_control_2,
    output logic [7:0] second_tub_control_1,
    output logic [7:0] second_tub_control_2
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [5:0]     HMOD       = 6'(HOUR_MOD);
    localparam logic [5:0]     MOD60      = 6'd60;
    localparam logic [7:0]     TUB_BLANK  = (SEG_ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;

    mode_t         mode;
    field_t        field_q;
    logic [PW-1:0] presc_q;
    logic [4:0]    hour_q;
    logic [5:0]    min_q;
    logic [5:0]    sec_q;
    logic          tick_q;
    logic          alarm_q;
    logic          sel_q;
    logic          inc_q;
    logic          dec_q;

    logic          sel_edge;
    logic          inc_edge;
    logic          dec_edge;

    logic [5:0]    sec_n;
    logic [5:0]    min_n;
    logic [4:0]    hour_n;
    logic          alarm_match;

    logic [5:0]    set_val;
    logic [5:0]    set_mod;
    logic [5:0]    set_adj;

    logic [7:0]    dec_h1, dec_h2, dec_m1, dec_m2, dec_s1, dec_s2;
    logic          blank;

    // Operating mode from power and set inputs (OFF beats SET beats RUN).
    always_comb begin
        mode = MODE_RUN;
        if (!power_state)
            mode = MODE_OFF;
        else if (set_mode)
            mode = MODE_SET;
    end

    assign sel_edge = select_key   & ~sel_q;
    assign inc_edge = increase_key & ~inc_q;
    assign dec_edge = decrease_key & ~dec_q;

    // Next time on a tick with seconds -> minutes -> hours carry, plus alarm compare.
    always_comb begin
        sec_n  = wrap_inc(sec_q, MOD60);
        min_n  = min_q;
        hour_n = hour_q;
        if (sec_q == 6'd59) begin
            min_n = wrap_inc(min_q, MOD60);
            if (min_q == 6'd59)
                hour_n = 5'(wrap_inc({1'b0, hour_q}, HMOD));
        end
        alarm_match = alarm_en
                      && ({1'b0, alarm_hour} < HMOD)
                      && (alarm_min < MOD60)
                      && (sec_n == '0)
                      && (min_n == alarm_min)
                      && (hour_n == alarm_hour);
    end

    // Adjusted value of the selected field; simultaneous inc and dec cancel.
    always_comb begin
        set_val = sec_q;
        set_mod = MOD60;
        case (field_q)
            FIELD_MIN:  set_val = min_q;
            FIELD_HOUR: begin
                set_val = {1'b0, hour_q};
                set_mod = HMOD;
            end
            default:    set_val = sec_q;
        endcase
        set_adj = set_val;
        if (inc_edge && !dec_edge)
            set_adj = wrap_inc(set_val, set_mod);
        else if (dec_edge && !inc_edge)
            set_adj = wrap_dec(set_val, set_mod);
    end

    // Key history: sampled every cycle regardless of mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= 1'b0;
            inc_q <= 1'b0;
            dec_q <= 1'b0;
        end else begin
            sel_q <= select_key;
            inc_q <= increase_key;
            dec_q <= decrease_key;
        end
    end

    // Mode-driven time keeping: count in RUN, adjust in SET, hold in OFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            field_q <= FIELD_MIN;
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            case (mode)
                MODE_RUN: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_q <= '0;
                        tick_q  <= 1'b1;
                        alarm_q <= alarm_match;
                        sec_q   <= sec_n;
                        min_q   <= min_n;
                        hour_q  <= hour_n;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                        tick_q  <= 1'b0;
                        alarm_q <= 1'b0;
                    end
                end
                MODE_SET: begin
                    presc_q <= '0;
                    tick_q  <= 1'b0;
                    alarm_q <= 1'b0;
                    // The adjustment targets the field selected before this
                    // cycle's select edge takes effect.
                    case (field_q)
                        FIELD_MIN:  min_q  <= set_adj;
                        FIELD_HOUR: hour_q <= 5'(set_adj);
                        default:    sec_q  <= set_adj;
                    endcase
                    if (sel_edge)
                        field_q <= next_field(field_q);
                end
                default: begin
                    tick_q  <= 1'b0;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    assign blank = (mode == MODE_OFF);

    seg7_digit_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_h1 (
        .digit(digit_tens({1'b0, hour_q})), .blank(blank), .pattern(dec_h1));
    seg7_digit_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_h2 (
        .digit(digit_units({1'b0, hour_q})), .blank(blank), .pattern(dec_h2));
    seg7_digit_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_m1 (
        .digit(digit_tens(min_q)), .blank(blank), .pattern(dec_m1));
    seg7_digit_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_m2 (
        .digit(digit_units(min_q)), .blank(blank), .pattern(dec_m2));
    seg7_digit_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_s1 (
        .digit(digit_tens(sec_q)), .blank(blank), .pattern(dec_s1));
    seg7_digit_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_s2 (
        .digit(digit_units(sec_q)), .blank(blank), .pattern(dec_s2));

    // Registered display buses, one cycle behind the time registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hour_tub_control_1   <= TUB_BLANK;
            hour_tub_control_2   <= TUB_BLANK;
            minute_tub_control_1 <= TUB_BLANK;
            minute_tub_control_2 <= TUB_BLANK;
            second_tub_control_1 <= TUB_BLANK;
            second_tub_control_2 <= TUB_BLANK;
        end else begin
            hour_tub_control_1   <= dec_h1;
            hour_tub_control_2   <= dec_h2;
            minute_tub_control_1 <= dec_m1;
            minute_tub_control_2 <= dec_m2;
            second_tub_control_1 <= dec_s1;
            second_tub_control_2 <= dec_s2;
        end
    end

    assign hours     = hour_q;
    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign set_field = field_q;
    assign tick_1hz  = tick_q;
    assign alarm_hit = alarm_q;

endmodule

// File: tb/tb_timer_clock_gen2.sv
// Directed bench for timer_clock_gen2 with TICK_DIV=4, in 24h and 12h variants.
module tb_timer_clock_gen2;

    logic       clk = 1'b0;
    logic       reset;
    logic       power_state;
    logic       set_mode;
    logic       select_key;
    logic       increase_key;
    logic       decrease_key;
    logic       alarm_en;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;

    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic [1:0] set_field;
    logic       tick_1hz, alarm_hit;
    logic [7:0] ht1, ht2, mt1, mt2, st1, st2;

    logic [4:0] h12;
    logic [5:0] m12, s12;
    logic [1:0] f12;
    logic       t12, a12;
    logic [7:0] ht1_12, ht2_12, mt1_12, mt2_12, st1_12, st2_12;

    logic [47:0] tubs;
    assign tubs = {ht1, ht2, mt1, mt2, st1, st2};

    int n_cmp    = 0;
    int n_bad    = 0;
    int tick_cnt = 0;
    int hit_cnt  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    timer_clock_gen2 #(.TICK_DIV(4), .HOUR_MOD(24), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .power_state(power_state), .set_mode(set_mode),
        .select_key(select_key), .increase_key(increase_key), .decrease_key(decrease_key),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .hours(hours), .minutes(minutes), .seconds(seconds), .set_field(set_field),
        .tick_1hz(tick_1hz), .alarm_hit(alarm_hit),
        .hour_tub_control_1(ht1), .hour_tub_control_2(ht2),
        .minute_tub_control_1(mt1), .minute_tub_control_2(mt2),
        .second_tub_control_1(st1), .second_tub_control_2(st2));

    timer_clock_gen2 #(.TICK_DIV(4), .HOUR_MOD(12), .SEG_ACTIVE_LOW(1)) dut12 (
        .clk(clk), .reset(reset), .power_state(power_state), .set_mode(set_mode),
        .select_key(select_key), .increase_key(increase_key), .decrease_key(decrease_key),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .hours(h12), .minutes(m12), .seconds(s12), .set_field(f12),
        .tick_1hz(t12), .alarm_hit(a12),
        .hour_tub_control_1(ht1_12), .hour_tub_control_2(ht2_12),
        .minute_tub_control_1(mt1_12), .minute_tub_control_2(mt2_12),
        .second_tub_control_1(st1_12), .second_tub_control_2(st2_12));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; outputs are observed 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (tick_1hz)  tick_cnt++;
            if (alarm_hit) hit_cnt++;
        end
    endtask

    // 0 = select, 1 = increase, 2 = decrease: one-cycle press then release.
    task automatic press(input int which);
        select_key   = (which == 0);
        increase_key = (which == 1);
        decrease_key = (which == 2);
        step(1);
        select_key   = 1'b0;
        increase_key = 1'b0;
        decrease_key = 1'b0;
        step(1);
    endtask

    initial begin
        int last_tick;
        int gap_bad;
        int t0;

        reset = 1'b1; power_state = 1'b1; set_mode = 1'b0;
        select_key = 1'b0; increase_key = 1'b0; decrease_key = 1'b0;
        alarm_en = 1'b0; alarm_hour = 5'd7; alarm_min = 6'd30;
        step(2);

        // Reset state
        check("rst_time", {hours, minutes, seconds}, 17'd0);
        check("rst_field", set_field, 2'd1);
        check("rst_tick", {tick_1hz, alarm_hit}, 2'b00);
        check("rst_tubs", tubs, 48'hFFFF_FFFF_FFFF);

        // Free run 240 cycles: 60 ticks, 4 cycles apart
        reset = 1'b0;
        cyc = 0; tick_cnt = 0; last_tick = 0; gap_bad = 0;
        for (int i = 0; i < 240; i++) begin
            step(1);
            if (tick_1hz) begin
                if (cyc - last_tick != 4) gap_bad++;
                last_tick = cyc;
            end
        end
        check("run_ticks", tick_cnt, 60);
        check("run_gaps", gap_bad, 0);
        check("run_time", {hours, minutes, seconds}, {5'd0, 6'd1, 6'd0});
        check("run_time12", {h12, m12, s12}, {5'd0, 6'd1, 6'd0});
        check("run_noalarm", hit_cnt, 0);
        step(1);
        check("run_tubs", tubs, {8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hC0});

        // Preload 23:59:59 / 11:59:59 through SET
        set_mode = 1'b1;
        step(1);
        press(2); press(2);
        check("set_min_wrap", minutes, 6'd59);
        press(0);
        check("set_field_hour", set_field, 2'd2);
        press(2);
        check("set_hour_dec24", hours, 5'd23);
        check("set_hour_dec12", h12, 5'd11);
        press(0);
        check("set_field_sec", set_field, 2'd0);
        press(2);
        check("set_sec_dec", seconds, 6'd59);

        increase_key = 1'b1; decrease_key = 1'b1;
        step(1);
        increase_key = 1'b0; decrease_key = 1'b0;
        step(1);
        check("set_incdec_cancel", seconds, 6'd59);

        increase_key = 1'b1;
        step(5);
        check("set_held_one", seconds, 6'd0);
        increase_key = 1'b0;
        step(1);
        check("set_held_after", seconds, 6'd0);
        press(2);

        select_key = 1'b1; decrease_key = 1'b1;
        step(1);
        select_key = 1'b0; decrease_key = 1'b0;
        step(1);
        check("set_seldec_val", {minutes, seconds}, {6'd59, 6'd58});
        check("set_seldec_field", set_field, 2'd1);
        press(0); press(0); press(1);
        check("set_preload", {hours, minutes, seconds}, {5'd23, 6'd59, 6'd59});

        // First tick after SET comes exactly 4 cycles later; day rollover
        set_mode = 1'b0;
        t0 = tick_cnt;
        step(3);
        check("leave_no_tick", tick_cnt - t0, 0);
        check("leave_hold", seconds, 6'd59);
        step(1);
        check("leave_tick", tick_1hz, 1'b1);
        check("roll24", {hours, minutes, seconds}, 17'd0);
        check("roll12", {h12, m12, s12}, 17'd0);

        // Alarm 07:30 enabled: preload 07:29:59, passing 07:30:00 while in SET
        set_mode = 1'b1; alarm_en = 1'b1;
        step(1);
        press(2);
        press(0);
        for (int i = 0; i < 29; i++) press(1);
        press(0);
        for (int i = 0; i < 7; i++) press(1);
        press(0); press(1);
        press(0); press(1);
        check("set_at_alarm", {hours, minutes, seconds}, {5'd7, 6'd30, 6'd0});
        check("set_no_alarm", hit_cnt, 0);
        press(2); press(0); press(0); press(2);
        check("alarm_preload", {hours, minutes, seconds}, {5'd7, 6'd29, 6'd59});
        set_mode = 1'b0;
        step(3);
        check("alarm_early", alarm_hit, 1'b0);
        step(1);
        check("alarm_pulse", {tick_1hz, alarm_hit}, 2'b11);
        check("alarm_time", {hours, minutes, seconds}, {5'd7, 6'd30, 6'd0});
        step(1);
        check("alarm_one_cycle", alarm_hit, 1'b0);
        check("alarm_count", hit_cnt, 1);
        check("alarm_tubs", tubs, {8'hC0, 8'hF8, 8'hB0, 8'hC0, 8'hC0, 8'hC0});

        // Same crossing with alarm disabled
        set_mode = 1'b1; alarm_en = 1'b0;
        step(1);
        press(2); press(0); press(2);
        set_mode = 1'b0;
        step(4);
        check("noalarm_tick", {tick_1hz, alarm_hit}, 2'b10);
        check("noalarm_time", {hours, minutes, seconds}, {5'd7, 6'd30, 6'd0});
        check("noalarm_count", hit_cnt, 1);

        // Power off mid-count: hold time and prescaler, blank display
        step(2);
        power_state = 1'b0;
        t0 = tick_cnt;
        step(10);
        check("off_time", {hours, minutes, seconds}, {5'd7, 6'd30, 6'd0});
        check("off_tubs", tubs, 48'hFFFF_FFFF_FFFF);
        check("off_ticks", tick_cnt - t0, 0);
        power_state = 1'b1;
        step(1);
        check("on_resume_wait", {tick_1hz, seconds}, {1'b0, 6'd0});
        step(1);
        check("on_resume_tick", {tick_1hz, seconds}, {1'b1, 6'd1});

        // Reset mid-count
        step(1);
        reset = 1'b1;
        step(1);
        check("rst_mid_time", {hours, minutes, seconds}, 17'd0);
        check("rst_mid_field", set_field, 2'd1);
        check("rst_mid_tubs", tubs, 48'hFFFF_FFFF_FFFF);
        reset = 1'b0;
        step(3);
        check("rst_mid_presc_wait", tick_1hz, 1'b0);
        step(1);
        check("rst_mid_presc_tick", {tick_1hz, seconds}, {1'b1, 6'd1});

        // Reset mid-SET
        set_mode = 1'b1;
        step(1);
        press(0); press(1);
        check("rst_set_pre", {set_field, hours}, {2'd2, 5'd1});
        reset = 1'b1;
        step(1);
        check("rst_set_time", {hours, minutes, seconds}, 17'd0);
        check("rst_set_field", set_field, 2'd1);
        check("rst_set_tubs", tubs, 48'hFFFF_FFFF_FFFF);
        reset = 1'b0; set_mode = 1'b0;
        step(3);
        check("rst_set_wait", tick_1hz, 1'b0);
        step(1);
        check("rst_set_tick", tick_1hz, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
